// File: rtl/i2c_reg_target.sv
// Clocked I2C target exposing four 8-bit registers with an auto-incrementing pointer.
// SCL/SDA are oversampled on clk; START/STOP/edge events are registered one-cycle pulses.
`timescale 1ns/1ps
module i2c_reg_target (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  addr,
  input  logic        SCL,
  inout  wire         SDA,
  output logic [31:0] regs,
  output logic        wr_strobe,
  output logic [1:0]  wr_idx,
  output logic        busy
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_IGNORE    = 4'd9;

  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic       scl_rise, scl_fall, start_ev, stop_ev;
  logic [3:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [1:0] ptr;
  logic       rw;
  logic       sda_oe;
  logic [7:0] rx_byte;
  logic [7:0] cur_reg;

  assign SDA     = sda_oe ? 1'b0 : 1'bz;
  // sda_d holds the SDA level seen when the SCL edge was detected
  assign rx_byte = {shreg[6:0], sda_d};
  assign cur_reg = regs[{ptr, 3'b000} +: 8];

  // Synchronizers idle high so reset release never fakes a bus event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_d    <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_d    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start_ev <= 1'b0;
      stop_ev  <= 1'b0;
    end else begin
      scl_s1   <= SCL;
      scl_s2   <= scl_s1;
      scl_d    <= scl_s2;
      sda_s1   <= SDA;
      sda_s2   <= sda_s1;
      sda_d    <= sda_s2;
      scl_rise <= scl_s2 & ~scl_d;
      scl_fall <= ~scl_s2 & scl_d;
      start_ev <= scl_s2 & scl_d & sda_d & ~sda_s2;
      stop_ev  <= scl_s2 & scl_d & ~sda_d & sda_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      regs      <= '0;
      wr_strobe <= 1'b0;
      wr_idx    <= '0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_ev) begin
        state   <= S_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_ev) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == addr && addr != 7'h00) begin
                state <= S_ADDR_ACK;
                rw    <= rx_byte[0];
                busy  <= 1'b1;
              end else begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          // First fall drives ACK low, second fall ends the ACK slot
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              bit_cnt <= '0;
              if (state == S_ADDR_ACK && rw) begin
                shreg  <= cur_reg;
                sda_oe <= ~cur_reg[7];
                state  <= S_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= (state == S_ADDR_ACK) ? S_PTR : S_WDATA;
              end
            end
          end
          S_PTR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= rx_byte[1:0];
              state <= S_PTR_ACK;
            end
          end
          S_WDATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              regs[{ptr, 3'b000} +: 8] <= rx_byte;
              wr_strobe <= 1'b1;
              wr_idx    <= ptr;
              ptr       <= ptr + 2'd1;
              state     <= S_WDATA_ACK;
            end
          end
          // bit_cnt wraps to 0 after the 8th rise, marking the byte's final fall
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= S_RDATA_ACK;
              end else begin
                sda_oe <= ~shreg[6];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_d) begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end else begin
                ptr <= ptr + 2'd1;
              end
            end else if (scl_fall) begin
              shreg   <= cur_reg;
              sda_oe  <= ~cur_reg[7];
              bit_cnt <= '0;
              state   <= S_RDATA;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master, array model of the register bank.
`timescale 1ns/1ps
module tb_i2c_reg_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  addr = 7'h42;
  logic        scl_drv = 1'b1;
  logic        m_low = 1'b0;
  wire         sda_bus;
  logic [31:0] regs;
  logic        wr_strobe;
  logic [1:0]  wr_idx;
  logic        busy;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  i2c_reg_target dut (
    .clk(clk), .rst(rst), .addr(addr), .SCL(scl_drv), .SDA(sda_bus),
    .regs(regs), .wr_strobe(wr_strobe), .wr_idx(wr_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam time Q = 100;  // quarter SCL period = 10 clk (40x oversampling)

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mregs [4];
  int         mptr = 0;
  logic [7:0] wbytes [$];
  int         strobe_q [$];
  int         width_bad = 0;
  logic       strobe_prev = 1'b0;
  logic       dut_low = 1'b0;

  always @(negedge clk) begin
    #1;
    if (wr_strobe) begin
      strobe_q.push_back(int'(wr_idx));
      if (strobe_prev) width_bad++;
    end
    strobe_prev = wr_strobe;
    if (!sda_bus && !m_low) dut_low = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_word();
    return {mregs[3], mregs[2], mregs[1], mregs[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    m_low = 1'b0; #Q;
    scl_drv = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic put_bit(input logic b);
    m_low = ~b; #Q;
    scl_drv = 1'b1; #(2*Q);
    scl_drv = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_low = 1'b0; #Q;
    scl_drv = 1'b1; #Q;
    b = sda_bus; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  // Write transaction to device 0x42: pointer byte then every byte in wbytes
  task automatic wr_txn(input logic [7:0] pb);
    logic ack;
    int   p;
    int   exp_idx [$];
    strobe_q.delete();
    i2c_start();
    write_byte(8'h84, ack); check("wr_addr_ack", 32'(ack), 32'd1);
    write_byte(pb, ack);    check("wr_ptr_ack", 32'(ack), 32'd1);
    p = int'(pb[1:0]);
    foreach (wbytes[i]) begin
      write_byte(wbytes[i], ack);
      check("wr_data_ack", 32'(ack), 32'd1);
      mregs[p] = wbytes[i];
      exp_idx.push_back(p);
      p = (p + 1) % 4;
    end
    mptr = p;
    i2c_stop();
    check("strobe_count", 32'(strobe_q.size()), 32'(exp_idx.size()));
    foreach (exp_idx[i])
      if (i < strobe_q.size()) check("wr_idx", 32'(strobe_q[i]), 32'(exp_idx[i]));
    check("regs_after_write", regs, model_word());
  endtask

  // Set pointer, repeated START, read n bytes (ACK all but the last)
  task automatic rd_txn(input logic [7:0] pb, input int n);
    logic       ack;
    logic [7:0] d;
    int         p;
    i2c_start();
    write_byte(8'h84, ack); check("rd_addr_ack", 32'(ack), 32'd1);
    write_byte(pb, ack);    check("rd_ptr_ack", 32'(ack), 32'd1);
    p = int'(pb[1:0]);
    i2c_start();
    write_byte(8'h85, ack); check("rd_addr2_ack", 32'(ack), 32'd1);
    check("busy_in_read", 32'(busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      read_byte(d, k != n - 1);
      check("rd_data", 32'(d), 32'(mregs[p]));
      if (k != n - 1) p = (p + 1) % 4;
    end
    check("busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();
    mptr = p;
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] pb;
    int         n;
    foreach (mregs[i]) mregs[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_regs", regs, 32'h0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_idx", 32'(wr_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sda", 32'(sda_bus), 32'd1);
    rst = 1'b0;
    #Q;

    // Write with pointer wrap 2 -> 3 -> 0
    wbytes = '{8'hA1, 8'hB2, 8'hC3};
    wr_txn(8'h02);

    // Repeated-START read from pointer 3, expecting B2 then C3
    rd_txn(8'h03, 2);

    // Address mismatch
    dut_low = 1'b0;
    strobe_q.delete();
    i2c_start();
    write_byte(8'h86, ack); check("mismatch_nack", 32'(ack), 32'd0);
    write_byte(8'h55, ack); check("mismatch_data_nack", 32'(ack), 32'd0);
    check("mismatch_busy", 32'(busy), 32'd0);
    i2c_stop();
    check("mismatch_sda_never_low", 32'(dut_low), 32'd0);
    check("mismatch_regs", regs, model_word());
    check("mismatch_strobes", 32'(strobe_q.size()), 32'd0);

    // General call is never acknowledged
    addr = 7'h00;
    strobe_q.delete();
    i2c_start();
    write_byte(8'h00, ack); check("gencall_nack", 32'(ack), 32'd0);
    write_byte(8'h11, ack); check("gencall_data_nack", 32'(ack), 32'd0);
    check("gencall_busy", 32'(busy), 32'd0);
    i2c_stop();
    check("gencall_strobes", 32'(strobe_q.size()), 32'd0);
    check("gencall_regs", regs, model_word());
    addr = 7'h42;

    // Reset while the target drives a 0 bit of reg0 (C3 = 1100_0011)
    i2c_start();
    write_byte(8'h84, ack); check("rstrd_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h00, ack); check("rstrd_ptr_ack", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'h85, ack); check("rstrd_addr2_ack", 32'(ack), 32'd1);
    get_bit(b); check("rstrd_bit7", 32'(b), 32'(mregs[0][7]));
    get_bit(b); check("rstrd_bit6", 32'(b), 32'(mregs[0][6]));
    check("rstrd_bit5_driven", 32'(sda_bus), 32'(mregs[0][5]));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstrd_sda_released", 32'(sda_bus), 32'd1);
    check("rstrd_regs", regs, 32'h0);
    check("rstrd_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    foreach (mregs[i]) mregs[i] = 8'h00;
    mptr = 0;
    i2c_stop();
    wbytes = '{8'h5A};
    wr_txn(8'h00);

    // STOP after four data bits of a write
    strobe_q.delete();
    i2c_start();
    write_byte(8'h84, ack); check("abort_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h01, ack); check("abort_ptr_ack", 32'(ack), 32'd1);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    i2c_stop();
    #Q;
    check("abort_strobes", 32'(strobe_q.size()), 32'd0);
    check("abort_regs", regs, model_word());
    check("abort_busy", 32'(busy), 32'd0);
    wbytes = '{8'h77};
    wr_txn(8'h01);

    // Randomized writes and reads against the array model
    for (int it = 0; it < 6; it++) begin
      pb = 8'($urandom);
      n = int'($urandom_range(1, 5));
      wbytes.delete();
      for (int k = 0; k < n; k++) wbytes.push_back(8'($urandom));
      wr_txn(pb);
      rd_txn(8'($urandom), int'($urandom_range(1, 5)));
    end

    check("strobe_width", 32'(width_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
